// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg: shared constants for the MIPS load/store unit.
//   - LSU_DW         : datapath/memory word width (fixed at 32)
//   - lsu_size_e     : request size encoding (byte/half/word/reserved)
//   - ST_*           : FSM state encoding used by mips_lsu
//   - lsu_req_err()  : decides whether a request is rejected without a memory access
package mips_lsu_pkg;

  localparam int unsigned LSU_DW = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // A request errors on a reserved size, natural misalignment, or a word index past the memory.
  function automatic logic lsu_req_err(input logic [1:0] size, input logic [31:0] addr,
                                       input int unsigned depth);
    logic bad_align;
    logic bad_range;
    case (size)
      SZ_HALF: bad_align = addr[0];
      SZ_WORD: bad_align = |addr[1:0];
      SZ_RSVD: bad_align = 1'b1;
      default: bad_align = 1'b0;
    endcase
    bad_range = ({2'b00, addr[31:2]} >= depth);
    return bad_align | bad_range;
  endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// mips_lsu_if: request/response handshake plus word-addressed memory port of the LSU.
//   req_*  : datapath -> LSU request (valid/ready)
//   resp_* : LSU -> datapath response (valid/ready)
//   mem_*  : LSU <-> data memory; mem_rd is combinational in mem_addr
// Modports: slave = the LSU itself, master = its environment (datapath + memory).
interface mips_lsu_if;
  import mips_lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [LSU_DW-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [LSU_DW-1:0] resp_rdata;
  logic              resp_err;

  logic [31:0]       mem_addr;
  logic              mem_we;
  logic [LSU_DW-1:0] mem_wd;
  logic [LSU_DW-1:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_addr, mem_we, mem_wd,
    input  mem_rd
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_addr, mem_we, mem_wd,
    output mem_rd
  );

endinterface

// File: rtl/mips_lsu_align.sv
// mips_lsu_align: combinational little-endian lane logic for the LSU.
//   word_i     : word read from memory
//   off_i      : byte offset within the word (addr[1:0])
//   size_i     : access size (lsu_size_e encoding)
//   unsigned_i : 1 = zero-extend loads, 0 = sign-extend
//   wdata_i    : right-aligned store data
//   load_o     : extracted and extended load data
//   merge_o    : word_i with the store lane(s) replaced by wdata_i
module mips_lsu_align
  import mips_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        byte_sign;
  logic        half_sign;

  always_comb begin
    byte_v    = word_i[{off_i, 3'b000} +: 8];
    half_v    = word_i[{off_i[1], 4'b0000} +: 16];
    byte_sign = ~unsigned_i & byte_v[7];
    half_sign = ~unsigned_i & half_v[15];

    case (size_i)
      SZ_BYTE: load_o = {{(DATA_W - 8){byte_sign}}, byte_v};
      SZ_HALF: load_o = {{(DATA_W - 16){half_sign}}, half_v};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    case (size_i)
      SZ_BYTE: merge_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit between the MIPS datapath and a word-addressed data memory.
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : mips_lsu_if.slave (request/response handshake + memory port)
// Loads read one word and extend the selected lane. Word stores write directly; byte/half
// stores read the word, merge the new lane and write it back. Erroring requests go straight
// to the response state without touching memory.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  mips_lsu_if.slave bus
);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;

  mips_lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .word_i    (bus.mem_rd),
    .off_i     (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .wdata_i   (wdata_q),
    .load_o    (load_data),
    .merge_o   (merge_data)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = lsu_req_err(bus.req_size, bus.req_addr, DEPTH);
          if (err_d) begin
            state_d = ST_RESP;
          end else if (!bus.req_we) begin
            state_d = ST_READ;
          end else if (bus.req_size == SZ_WORD) begin
            state_d = ST_WRITE;
          end else begin
            // Sub-word store: fetch the word first so the other lanes survive.
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (we_q) begin
          wdata_d = merge_data;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // rst gates the handshake and the write strobe so a reset edge that lands on WRITE
  // cannot commit the write or hand out a response.
  assign bus.req_ready  = (state_q == ST_IDLE) & ~rst;
  assign bus.resp_valid = (state_q == ST_RESP) & ~rst;
  assign bus.resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
  assign bus.resp_err   = (state_q == ST_RESP) & err_q;
  assign bus.mem_addr   = ((state_q == ST_READ) || (state_q == ST_WRITE)) ?
                          {2'b00, addr_q[31:2]} : '0;
  assign bus.mem_we     = (state_q == ST_WRITE) & ~rst;
  assign bus.mem_wd     = (state_q == ST_WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: self-checking bench for mips_lsu with a behavioural memory and reference model.
module tb_mips_lsu;
  import mips_lsu_pkg::*;

  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_lsu_if bus ();

  mips_lsu #(
    .DEPTH (DEPTH),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Data memory owned by the bench; backdoor pokes go through the same process.
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  int          wr_count = 0;

  assign bus.mem_rd = (bus.mem_addr < DEPTH) ? mem[bus.mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_addr < DEPTH) mem[bus.mem_addr[7:0]] <= bus.mem_wd;
      wr_count <= wr_count + 1;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = idx;
    bd_data = data;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
  endtask

  // One full transaction; lat is the number of edges after the accept edge at which
  // resp_valid is first seen (0 = never seen within the budget).
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int nwr, output logic touched);
    int w0;
    int k;
    rd = '0; er = 1'b0; lat = 0; touched = 1'b0;
    @(negedge clk);
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    drive(we, sz, uns, addr, wd);
    bus.resp_ready = (hold == 0);
    w0 = wr_count;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = i;
        break;
      end
      if (bus.mem_we || bus.mem_addr != 32'h0) touched = 1'b1;
    end
    if (lat != 0) begin
      rd = bus.resp_rdata;
      er = bus.resp_err;
      repeat (hold) @(negedge clk);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    nwr = wr_count - w0;
  endtask

  // Reference: plain arithmetic on a word array, straight from the lane/extension rules.
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er, output int lat,
                                output int nwr);
    logic [29:0] idx;
    logic [31:0] w, v, mask;
    idx = addr[31:2];
    er  = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0) ||
          (idx >= DEPTH);
    rd  = 32'h0;
    nwr = 0;
    if (er) begin
      lat = 1;
    end else begin
      w = ref_mem[idx[7:0]];
      if (!we) begin
        lat = 2;
        if (sz == 2'd0) begin
          v = (w >> (8 * addr[1:0])) & 32'hFF;
          if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
          v = (w >> (16 * addr[1])) & 32'hFFFF;
          if (!uns && v >= 32768) v = v - 65536;
        end else begin
          v = w;
        end
        rd = v;
      end else begin
        lat = (sz == 2'd2) ? 2 : 3;
        nwr = 1;
        if (sz == 2'd0)      mask = 32'hFF << (8 * addr[1:0]);
        else if (sz == 2'd1) mask = 32'hFFFF << (16 * addr[1]);
        else                 mask = 32'hFFFF_FFFF;
        ref_mem[idx[7:0]] = (w & ~mask) | ((wd << (8 * addr[1:0])) & mask);
      end
    end
  endfunction

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vt[24];

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er, touched;
    int          lat, nwr, k;

    // mem[3] = 887766F5, mem[255] = CAFEF00D at the start of the table.
    vt[0]  = '{1'b0, 2'd0, 1'b0, 32'h0D,  32'h0,        32'h0000_0066, 1'b0, 2, 0};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 32'h0C,  32'h0,        32'hFFFF_FFF5, 1'b0, 2, 0};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 32'h0F,  32'h0,        32'h0000_0088, 1'b0, 2, 0};
    vt[3]  = '{1'b0, 2'd0, 1'b0, 32'h0F,  32'h0,        32'hFFFF_FF88, 1'b0, 2, 0};
    vt[4]  = '{1'b0, 2'd1, 1'b0, 32'h0E,  32'h0,        32'hFFFF_8877, 1'b0, 2, 0};
    vt[5]  = '{1'b0, 2'd1, 1'b1, 32'h0C,  32'h0,        32'h0000_66F5, 1'b0, 2, 0};
    vt[6]  = '{1'b1, 2'd2, 1'b0, 32'h0C,  32'h1122_3344, 32'h0,        1'b0, 2, 1};
    vt[7]  = '{1'b1, 2'd1, 1'b0, 32'h0E,  32'h0000_BEEF, 32'h0,        1'b0, 3, 1};
    vt[8]  = '{1'b0, 2'd2, 1'b0, 32'h0C,  32'h0,        32'hBEEF_3344, 1'b0, 2, 0};
    vt[9]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEAD_BEEF, 32'h0,        1'b0, 2, 1};
    vt[10] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEAD_BEEF, 1'b0, 2, 0};
    vt[11] = '{1'b1, 2'd0, 1'b0, 32'h11,  32'hFFFF_FFA5, 32'h0,        1'b0, 3, 1};
    vt[12] = '{1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        32'h0000_00A5, 1'b0, 2, 0};
    vt[13] = '{1'b0, 2'd1, 1'b0, 32'h10,  32'h0,        32'hFFFF_A5EF, 1'b0, 2, 0};
    vt[14] = '{1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0,        32'hCAFE_F00D, 1'b0, 2, 0};
    vt[15] = '{1'b0, 2'd0, 1'b0, 32'h3FF, 32'h0,        32'hFFFF_FFCA, 1'b0, 2, 0};
    vt[16] = '{1'b0, 2'd2, 1'b0, 32'h06,  32'h0,        32'h0,         1'b1, 1, 0};
    vt[17] = '{1'b0, 2'd1, 1'b0, 32'h03,  32'h0,        32'h0,         1'b1, 1, 0};
    vt[18] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h0,         1'b1, 1, 0};
    vt[19] = '{1'b0, 2'd3, 1'b0, 32'h0C,  32'h0,        32'h0,         1'b1, 1, 0};
    vt[20] = '{1'b1, 2'd0, 1'b0, 32'h400, 32'h77,       32'h0,         1'b1, 1, 0};
    vt[21] = '{1'b1, 2'd2, 1'b0, 32'h12,  32'h1234_5678, 32'h0,        1'b1, 1, 0};
    vt[22] = '{1'b1, 2'd1, 1'b0, 32'h13,  32'h0000_9999, 32'h0,        1'b1, 1, 0};
    vt[23] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEAD_A5EF, 1'b0, 2, 0};

    rst = 1'b1;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;

    poke(8'd3, 32'h8877_66F5);
    poke(8'd255, 32'hCAFE_F00D);
    @(negedge clk);
    check1("rst req_ready", bus.req_ready, 1'b0);
    rst = 1'b0;
    #1;
    check1("rst resp_valid", bus.resp_valid, 1'b0);
    check1("rst resp_err", bus.resp_err, 1'b0);
    check("rst resp_rdata", bus.resp_rdata, 32'h0);
    check1("rst mem_we", bus.mem_we, 1'b0);
    check("rst mem_wd", bus.mem_wd, 32'h0);
    check("rst mem_addr", bus.mem_addr, 32'h0);
    check1("idle req_ready", bus.req_ready, 1'b1);

    // Directed table.
    for (int i = 0; i < 24; i++) begin
      run_req(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wdata, 0, rd, er, lat, nwr,
              touched);
      check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
      check1($sformatf("vec%0d err", i), er, vt[i].exp_err);
      check($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
      check($sformatf("vec%0d writes", i), nwr, vt[i].exp_wr);
      if (vt[i].exp_err) check1($sformatf("vec%0d mem idle", i), touched, 1'b0);
    end

    // Sub-word store, cycle by cycle.
    poke(8'd6, 32'h1122_3344);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    drive(1'b1, 2'd1, 1'b0, 32'h1A, 32'h0000_BEEF);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("seqA T+1 mem_addr", bus.mem_addr, 32'd6);
    check1("seqA T+1 mem_we", bus.mem_we, 1'b0);
    @(negedge clk);
    check1("seqA T+2 mem_we", bus.mem_we, 1'b1);
    check("seqA T+2 mem_addr", bus.mem_addr, 32'd6);
    check("seqA T+2 mem_wd", bus.mem_wd, 32'hBEEF_3344);
    @(negedge clk);
    check1("seqA T+3 resp_valid", bus.resp_valid, 1'b1);
    check("seqA T+3 rdata", bus.resp_rdata, 32'h0);
    check1("seqA T+3 mem_we", bus.mem_we, 1'b0);
    check("seqA T+3 mem_addr", bus.mem_addr, 32'h0);
    @(posedge clk);
    #1;
    check("seqA mem[6]", mem[6], 32'hBEEF_3344);

    // Backpressure in RESP, then a request presented on the release edge.
    @(negedge clk);
    bus.resp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    k = 0;
    while (!bus.resp_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check1("seqB resp_valid", bus.resp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1($sformatf("seqB hold%0d valid", i), bus.resp_valid, 1'b1);
      check($sformatf("seqB hold%0d rdata", i), bus.resp_rdata, 32'hBEEF_3344);
      check1($sformatf("seqB hold%0d req_ready", i), bus.req_ready, 1'b0);
    end
    bus.resp_ready = 1'b1;
    drive(1'b0, 2'd0, 1'b1, 32'h0C, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check1("seqB ready after release", bus.req_ready, 1'b1);
    check1("seqB no resp after release", bus.resp_valid, 1'b0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check1("seqB T+1 resp_valid", bus.resp_valid, 1'b0);
    @(negedge clk);
    check1("seqB T+2 resp_valid", bus.resp_valid, 1'b1);
    check("seqB T+2 rdata", bus.resp_rdata, 32'h0000_0044);
    @(posedge clk);
    #1;

    // Reset landing on the WRITE cycle of a byte store.
    poke(8'd7, 32'h5566_7788);
    @(negedge clk);
    drive(1'b1, 2'd0, 1'b0, 32'h1C, 32'h11);
    k = wr_count;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check1("seqC in WRITE", bus.mem_we, 1'b1);
    rst = 1'b1;
    #1;
    check1("seqC mem_we under rst", bus.mem_we, 1'b0);
    check1("seqC req_ready under rst", bus.req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check1($sformatf("seqC post%0d resp_valid", i), bus.resp_valid, 1'b0);
      check1($sformatf("seqC post%0d mem_we", i), bus.mem_we, 1'b0);
      check("seqC post mem_addr", bus.mem_addr, 32'h0);
      @(negedge clk);
    end
    check1("seqC req_ready", bus.req_ready, 1'b1);
    check("seqC mem[7]", mem[7], 32'h5566_7788);
    check("seqC write count", wr_count - k, 32'd0);

    // Randomized phase against the reference model.
    for (int i = 0; i < 16; i++) begin
      rd = $urandom;
      poke(8'(i), rd);
      ref_mem[i] = rd;
    end
    rd = $urandom;
    poke(8'd255, rd);
    ref_mem[255] = rd;

    for (int n = 0; n < 250; n++) begin
      logic        r_we, r_uns, e_er;
      logic [1:0]  r_sz;
      logic [31:0] r_addr, r_wd, e_rd;
      int unsigned sel, idx;
      int          e_lat, e_nwr, hold;
      r_we  = 1'($urandom_range(0, 1));
      r_uns = 1'($urandom_range(0, 1));
      r_sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_wd  = $urandom;
      sel   = $urandom_range(0, 9);
      if (sel == 0) begin
        r_addr = $urandom;
      end else begin
        idx    = (sel == 1) ? 255 : $urandom_range(0, 15);
        r_addr = 32'((idx << 2) | $urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) begin
          if (r_sz == 2'd1) r_addr[0] = 1'b0;
          if (r_sz == 2'd2) r_addr[1:0] = 2'b00;
        end
      end
      hold = $urandom_range(0, 2);
      model(r_we, r_sz, r_uns, r_addr, r_wd, e_rd, e_er, e_lat, e_nwr);
      run_req(r_we, r_sz, r_uns, r_addr, r_wd, hold, rd, er, lat, nwr, touched);
      check($sformatf("rnd%0d rdata", n), rd, e_rd);
      check1($sformatf("rnd%0d err", n), er, e_er);
      check($sformatf("rnd%0d latency", n), lat, e_lat);
      check($sformatf("rnd%0d writes", n), nwr, e_nwr);
      if (e_er) check1($sformatf("rnd%0d mem idle", n), touched, 1'b0);
      if (r_we && !e_er) begin
        check($sformatf("rnd%0d mem word", n), mem[r_addr[9:2]], ref_mem[r_addr[9:2]]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
